// File: rtl/instruction_fetch_memory_if.sv
// Fetch and loader bus between the IF stage and instruction_fetch_memory.
// master drives the fetch/loader requests; slave is the memory block.
interface instruction_fetch_memory_if #(
  parameter int ADDR_WIDTH = 14
) ();
  logic [31:0]           PC;
  logic                  req;
  logic                  stall;
  logic                  flush;
  logic [31:0]           instruction;
  logic [31:0]           pcOut;
  logic                  valid;
  logic                  fault;
  logic [1:0]            faultCode;
  logic                  ready;
  logic                  ldEn;
  logic [ADDR_WIDTH-1:0] ldAddr;
  logic [7:0]            ldData;

  modport master (
    output PC, req, stall, flush, ldEn, ldAddr, ldData,
    input  instruction, pcOut, valid, fault, faultCode, ready
  );

  modport slave (
    input  PC, req, stall, flush, ldEn, ldAddr, ldData,
    output instruction, pcOut, valid, fault, faultCode, ready
  );
endinterface

// File: rtl/instruction_fetch_memory.sv
// Byte-addressed instruction memory with big-endian registered word fetch,
// stall/flush handling, fault reporting, byte loader and power-on clear.
module instruction_fetch_memory #(
  parameter int          ADDR_WIDTH     = 14,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000,
  parameter int          CLEAR_ON_RESET = 1
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_memory_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH - 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [7:0]    mem_r [DEPTH];

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   instr_r, instr_s;
  logic [31:0]   pc_out_r, pc_out_s;
  logic          valid_r, valid_s;
  logic          fault_r, fault_s;
  logic [1:0]    code_r, code_s;
  logic          ready_r, ready_s;
  logic          clr_we_s, ld_we_s;
  logic [1:0]    fetch_code_s;
  logic [CW-1:0] widx_s;

  // Bit1: address beyond the array (no wrap), bit0: not word aligned.
  function automatic logic [1:0] fetch_fault_code(input logic [31:0] pc);
    fetch_fault_code = {((pc >> ADDR_WIDTH) != 32'd0), (pc[1:0] != 2'b00)};
  endfunction

  assign fetch_code_s = fetch_fault_code(bus.PC);
  assign widx_s       = bus.PC[ADDR_WIDTH-1:2];

  // Next-state and next-output logic for the clear/ready sequencer and fetch pipe.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    instr_s  = instr_r;
    pc_out_s = pc_out_r;
    valid_s  = valid_r;
    fault_s  = fault_r;
    code_s   = code_r;
    clr_we_s = 1'b0;
    ld_we_s  = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (cnt_r == CNT_MAX) begin
          state_s = ST_READY;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_READY: begin
        ld_we_s = bus.ldEn;
        if (bus.flush) begin
          valid_s = 1'b0;
          fault_s = 1'b0;
          code_s  = 2'b00;
          instr_s = NOP_WORD;
        end else if (bus.stall) begin
          instr_s  = instr_r;
          pc_out_s = pc_out_r;
        end else if (bus.req) begin
          valid_s  = 1'b1;
          pc_out_s = bus.PC;
          code_s   = fetch_code_s;
          fault_s  = (fetch_code_s != 2'b00);
          if (fetch_code_s != 2'b00) begin
            instr_s = NOP_WORD;
          end else begin
            instr_s = {mem_r[{widx_s, 2'd0}], mem_r[{widx_s, 2'd1}],
                       mem_r[{widx_s, 2'd2}], mem_r[{widx_s, 2'd3}]};
          end
        end else begin
          valid_s = 1'b0;
          fault_s = 1'b0;
          code_s  = 2'b00;
          instr_s = NOP_WORD;
        end
      end
      default: begin
        state_s = RST_STATE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
    ready_s = (state_s == ST_READY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RST_STATE;
      cnt_r    <= {CW{1'b0}};
      instr_r  <= NOP_WORD;
      pc_out_r <= 32'd0;
      valid_r  <= 1'b0;
      fault_r  <= 1'b0;
      code_r   <= 2'b00;
      ready_r  <= (RST_STATE == ST_READY);
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      instr_r  <= instr_s;
      pc_out_r <= pc_out_s;
      valid_r  <= valid_s;
      fault_r  <= fault_s;
      code_r   <= code_s;
      ready_r  <= ready_s;
    end
  end

  // Array writes; the fetch above reads the pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst && clr_we_s) begin
      mem_r[{cnt_r, 2'd0}] <= 8'h00;
      mem_r[{cnt_r, 2'd1}] <= 8'h00;
      mem_r[{cnt_r, 2'd2}] <= 8'h00;
      mem_r[{cnt_r, 2'd3}] <= 8'h00;
    end else if (!rst && ld_we_s) begin
      mem_r[bus.ldAddr] <= bus.ldData;
    end
  end

  assign bus.instruction = instr_r;
  assign bus.pcOut       = pc_out_r;
  assign bus.valid       = valid_r;
  assign bus.fault       = fault_r;
  assign bus.faultCode   = code_r;
  assign bus.ready       = ready_r;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench for instruction_fetch_memory with ADDR_WIDTH=8 and a
// distinctive NOP word so NOP and cleared-zero results can be told apart.
module tb_instruction_fetch_memory;

  localparam int          AW  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cnt;
  logic saw_valid;

  instruction_fetch_memory_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch_memory #(
    .ADDR_WIDTH     (AW),
    .NOP_WORD       (NOP),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ld_byte(input logic [AW-1:0] a, input logic [7:0] d);
    bus.ldEn   = 1'b1;
    bus.ldAddr = a;
    bus.ldData = d;
    tick();
    bus.ldEn   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.PC  = pc;
    bus.req = 1'b1;
    tick();
  endtask

  task automatic wait_ready();
    cnt = 0;
    saw_valid = 1'b0;
    while (!bus.ready && cnt < 200) begin
      cnt++;
      tick();
      if (!bus.ready && bus.valid) saw_valid = 1'b1;
    end
  endtask

  initial begin
    bus.PC = 32'd0; bus.req = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.ldEn = 1'b0; bus.ldAddr = '0; bus.ldData = 8'h00;

    // Reset values, then clear duration
    rst = 1'b1;
    tick();
    chk("rst_instr", 64'(bus.instruction), 64'(NOP));
    chk("rst_pcout", 64'(bus.pcOut), 64'd0);
    chk("rst_flags", 64'({bus.valid, bus.fault, bus.faultCode, bus.ready}), 64'h0);
    rst = 1'b0;
    bus.req = 1'b1; bus.PC = 32'd0;
    wait_ready();
    chk("clear_len", 64'(cnt), 64'd64);
    chk("clear_novalid", 64'(saw_valid), 64'd0);

    // Every aligned word reads back zero after the clear
    for (int a = 0; a <= 252; a += 4) begin
      fetch(32'(a));
      chk($sformatf("sweep_%0d", a), {bus.instruction, 29'd0, bus.valid, bus.fault, 1'b0},
          {32'h0, 29'd0, 1'b1, 1'b0, 1'b0});
    end
    bus.req = 1'b0;
    tick();
    chk("idle", {bus.instruction, 30'd0, bus.valid, 1'b0}, {NOP, 30'd0, 1'b0, 1'b0});
    chk("idle_pcout", 64'(bus.pcOut), 64'd252);

    // Program image
    ld_byte(8'd100, 8'h48); ld_byte(8'd101, 8'h08); ld_byte(8'd102, 8'h00); ld_byte(8'd103, 8'h00);
    ld_byte(8'd104, 8'h24); ld_byte(8'd105, 8'h13); ld_byte(8'd106, 8'h00); ld_byte(8'd107, 8'h05);
    ld_byte(8'd200, 8'h24); ld_byte(8'd201, 8'h13); ld_byte(8'd202, 8'h00); ld_byte(8'd203, 8'h05);

    fetch(32'd100);
    chk("f100", {bus.instruction, bus.pcOut}, {32'h4808_0000, 32'd100});
    chk("f100_v", 64'({bus.valid, bus.fault}), 64'b10);
    fetch(32'd100);
    chk("b2b_100", {bus.instruction, bus.pcOut}, {32'h4808_0000, 32'd100});
    fetch(32'd104);
    chk("b2b_104", {bus.instruction, bus.pcOut}, {32'h2413_0005, 32'd104});
    chk("b2b_104_v", 64'(bus.valid), 64'd1);

    // Faults: {valid, fault, faultCode} and NOP instruction
    fetch(32'd102);
    chk("flt_mis", {bus.instruction, 28'd0, bus.valid, bus.fault, bus.faultCode}, {NOP, 28'd0, 4'b1101});
    fetch(32'd256);
    chk("flt_rng", {bus.instruction, 28'd0, bus.valid, bus.fault, bus.faultCode}, {NOP, 28'd0, 4'b1110});
    fetch(32'd257);
    chk("flt_both", {bus.instruction, 28'd0, bus.valid, bus.fault, bus.faultCode}, {NOP, 28'd0, 4'b1111});
    chk("flt_pcout", 64'(bus.pcOut), 64'd257);

    // Stall holds for three cycles while PC moves on
    fetch(32'd100);
    bus.stall = 1'b1; bus.PC = 32'd104;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_%0d", i), {bus.instruction, bus.pcOut}, {32'h4808_0000, 32'd100});
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall", {bus.instruction, bus.pcOut}, {32'h2413_0005, 32'd104});

    // Flush beats stall and req
    bus.flush = 1'b1; bus.stall = 1'b1; bus.PC = 32'd100;
    tick();
    chk("flush", {bus.instruction, 28'd0, bus.valid, bus.fault, bus.faultCode}, {NOP, 32'd0});
    chk("flush_pcout", 64'(bus.pcOut), 64'd104);
    bus.flush = 1'b0; bus.stall = 1'b0;

    // Read-before-write on the same byte
    bus.ldEn = 1'b1; bus.ldAddr = 8'd203; bus.ldData = 8'hFF;
    fetch(32'd200);
    bus.ldEn = 1'b0;
    chk("rbw_old", 64'(bus.instruction), 64'h2413_0005);
    fetch(32'd200);
    chk("rbw_new", 64'(bus.instruction), 64'h2413_00FF);

    // Reset at clear cycle 30; loader writes during clear must be dropped
    bus.req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("midclr_notready", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ldEn = 1'b1; bus.ldAddr = 8'd0; bus.ldData = 8'hAA;
    bus.req = 1'b1; bus.PC = 32'd0;
    wait_ready();
    bus.ldEn = 1'b0;
    chk("midclr_len", 64'(cnt), 64'd64);
    chk("midclr_novalid", 64'(saw_valid), 64'd0);
    fetch(32'd0);
    chk("midclr_ld0", {bus.instruction, 31'd0, bus.valid}, {32'h0, 31'd0, 1'b1});
    fetch(32'd100);
    chk("midclr_100", 64'(bus.instruction), 64'h0);
    fetch(32'd200);
    chk("midclr_200", 64'(bus.instruction), 64'h0);
    bus.req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
